uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_rx_cfg.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity encodings, receiver states and baud divisor helper
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO; a push into a full FIFO is dropped unless a pop frees a slot
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic                   drop,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((int'(count_q) < DEPTH) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign drop      = push && !do_push;
    assign count     = count_q;
endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with majority-vote sampling and a receive FIFO
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          break_det,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int BAUD_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CW       = $clog2(BAUD_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_MAX - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(BAUD_MAX / 2 - 1);

    // sync_q[0] is one stage from the pin, [1] is the synchronized line, [2] its history
    logic [2:0]           sync_q, sync_d;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop0_q, stop0_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_det_q, break_det_d;
    logic                 overrun_q, overrun_d;
    logic                 sample, bit_val, push, fifo_empty, fifo_drop;
    logic                 first_stop, any_stop_bad, par_fail, is_break;

    always_comb begin
        sync_d       = {sync_q[1:0], uart_rxd};
        // sync_q[0] is the value sync_q[1] will take next cycle, giving samples at MID-1, MID, MID+1
        bit_val      = (sync_q[0] & sync_q[1]) | (sync_q[0] & sync_q[2]) | (sync_q[1] & sync_q[2]);
        sample       = (baud_cnt_q == CNT_MID);
        first_stop   = (bit_cnt_q == 3'd0) ? bit_val : stop0_q;
        any_stop_bad = stop_bad_q | ~bit_val;
        par_fail     = ((PARITY == PARITY_ODD) && !(^shift_q ^ par_bit_q)) ||
                       ((PARITY == PARITY_EVEN) && (^shift_q ^ par_bit_q));
        is_break     = (shift_q == '0) && ((PARITY == PARITY_NONE) || !par_bit_q) && !first_stop;

        state_d      = state_q;
        baud_cnt_d   = (baud_cnt_q == CNT_LAST) ? '0 : baud_cnt_q + 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        stop0_d      = stop0_q;
        stop_bad_d   = stop_bad_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        break_det_d  = 1'b0;
        push         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (sync_q[2] && !sync_q[1]) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (sample) begin
                    state_d   = bit_val ? ST_IDLE : ST_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        bit_cnt_d  = 3'd0;
                        stop_bad_d = 1'b0;
                        state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    par_bit_d = bit_val;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    stop_bad_d = any_stop_bad;
                    if (bit_cnt_q == 3'd0) begin
                        stop0_d = bit_val;
                    end
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = 3'd0;
                        if (is_break) begin
                            break_det_d = 1'b1;
                        end else if (any_stop_bad) begin
                            frame_err_d = 1'b1;
                        end else if (par_fail) begin
                            parity_err_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overrun_d = fifo_drop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 3'b111;
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop0_q      <= 1'b1;
            stop_bad_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            stop0_q      <= stop0_d;
            stop_bad_q   <= stop_bad_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift_q),
        .pop       (rx_valid && rx_ready),
        .head_data (rx_data),
        .empty     (fifo_empty),
        .drop      (fifo_drop),
        .count     (fifo_count)
    );

    assign rx_valid   = !fifo_empty;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;
    localparam int FB = 16;
    localparam int SB = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rxd = 4'hf;
    logic       rx_ready_a = 1'b1, rx_ready_b = 1'b0, rx_ready_c = 1'b0, rx_ready_d = 1'b0;

    logic [7:0] rx_data_a, rx_data_c, rx_data_d;
    logic [6:0] rx_data_b;
    logic       rx_valid_a, rx_valid_b, rx_valid_c, rx_valid_d;
    logic [3:0] pe, fe, bd, ov;
    logic [4:0] cnt_a, cnt_b, cnt_c;
    logic [2:0] cnt_d;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_pe[4], n_fe[4], n_bd[4], n_ov[4];
    int s_pe, s_fe, s_bd, s_ov, t0, lat;
    logic [7:0] got;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 4; i++) begin
            n_pe[i] = 0; n_fe[i] = 0; n_bd[i] = 0; n_ov[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            n_pe[i] += int'(pe[i]);
            n_fe[i] += int'(fe[i]);
            n_bd[i] += int'(bd[i]);
            n_ov[i] += int'(ov[i]);
        end
    end

    uart_rx_cfg u_a (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .rx_ready(rx_ready_a), .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]),
        .overrun(ov[0]), .fifo_count(cnt_a)
    );

    uart_rx_cfg #(.CLK_FREQ(1600000), .UART_BPS(100000), .DATA_BITS(7), .PARITY(2)) u_b (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .rx_ready(rx_ready_b), .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]),
        .overrun(ov[1]), .fifo_count(cnt_b)
    );

    uart_rx_cfg #(.CLK_FREQ(1600000), .UART_BPS(100000), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[2]), .rx_data(rx_data_c), .rx_valid(rx_valid_c),
        .rx_ready(rx_ready_c), .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]),
        .overrun(ov[2]), .fifo_count(cnt_c)
    );

    uart_rx_cfg #(.CLK_FREQ(1600000), .UART_BPS(100000), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[3]), .rx_data(rx_data_d), .rx_valid(rx_valid_d),
        .rx_ready(rx_ready_d), .parity_err(pe[3]), .frame_err(fe[3]), .break_det(bd[3]),
        .overrun(ov[3]), .fifo_count(cnt_d)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic send_frame(input int lane, input logic [15:0] bits, input int nbits, input int bit_len);
        for (int i = 0; i < nbits; i++) begin
            rxd[lane] = bits[i];
            repeat (bit_len) @(negedge clk);
        end
        rxd[lane] = 1'b1;
        repeat (2 * bit_len) @(negedge clk);
    endtask

    task automatic snap(input int lane);
        s_pe = n_pe[lane]; s_fe = n_fe[lane]; s_bd = n_bd[lane]; s_ov = n_ov[lane];
    endtask

    task automatic pop_d(output logic [7:0] d);
        d = rx_data_d;
        rx_ready_d = 1'b1;
        @(negedge clk);
        rx_ready_d = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_valid", {rx_valid_a, rx_valid_b, rx_valid_c, rx_valid_d}, 4'h0);
        check_eq("reset_pulses", {pe, fe, bd, ov}, 16'h0);
        check_eq("reset_count_d", cnt_d, 3'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 at full rate: latency from the line falling edge
        snap(0);
        lat = -1;
        t0 = cyc;
        fork
            send_frame(0, {1'b1, 8'h55, 1'b0}, 10, SB);
            begin
                for (int i = 0; i < 6000; i++) begin
                    @(negedge clk);
                    if (rx_valid_a) begin
                        lat = cyc - t0;
                        got = rx_data_a;
                        break;
                    end
                end
            end
        join
        check_eq("a_latency_in_window", (lat >= 4121 && lat <= 4129), 1);
        check_eq("a_data", got, 8'h55);
        check_eq("a_errors", (n_pe[0] - s_pe) + (n_fe[0] - s_fe) + (n_bd[0] - s_bd) + (n_ov[0] - s_ov), 0);
        check_eq("a_count_after_pop", cnt_a, 5'd0);

        // 7E1: 0x41 has two ones, so the even parity bit is 0
        snap(1);
        send_frame(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10, FB);
        check_eq("b_count_good", cnt_b, 5'd1);
        check_eq("b_data", rx_data_b, 7'h41);
        check_eq("b_no_perr", n_pe[1] - s_pe, 0);
        send_frame(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10, FB);
        check_eq("b_perr", n_pe[1] - s_pe, 1);
        check_eq("b_count_kept", cnt_b, 5'd1);
        check_eq("b_no_ferr", n_fe[1] - s_fe, 0);

        // 8N2: good frame, then second stop bit low
        snap(2);
        send_frame(2, {1'b1, 1'b1, 8'hA3, 1'b0}, 11, FB);
        check_eq("c_count_good", cnt_c, 5'd1);
        check_eq("c_data", rx_data_c, 8'hA3);
        send_frame(2, {1'b0, 1'b1, 8'hA3, 1'b0}, 11, FB);
        check_eq("c_ferr", n_fe[2] - s_fe, 1);
        check_eq("c_no_break", n_bd[2] - s_bd, 0);
        check_eq("c_count_kept", cnt_c, 5'd1);

        // break: 12 bit times low, then a normal frame
        snap(3);
        rxd[3] = 1'b0;
        repeat (12 * FB) @(negedge clk);
        rxd[3] = 1'b1;
        repeat (2 * FB) @(negedge clk);
        check_eq("d_break", n_bd[3] - s_bd, 1);
        check_eq("d_break_no_ferr", n_fe[3] - s_fe, 0);
        check_eq("d_break_no_push", cnt_d, 3'd0);
        send_frame(3, {1'b1, 8'h3C, 1'b0}, 10, FB);
        check_eq("d_after_break_count", cnt_d, 3'd1);
        pop_d(got);
        check_eq("d_after_break_data", got, 8'h3C);

        // overrun: five words into a depth-4 FIFO with no consumer
        snap(3);
        send_frame(3, {1'b1, 8'h11, 1'b0}, 10, FB);
        send_frame(3, {1'b1, 8'h22, 1'b0}, 10, FB);
        send_frame(3, {1'b1, 8'h33, 1'b0}, 10, FB);
        send_frame(3, {1'b1, 8'h44, 1'b0}, 10, FB);
        send_frame(3, {1'b1, 8'h55, 1'b0}, 10, FB);
        check_eq("d_full_count", cnt_d, 3'd4);
        check_eq("d_overrun_once", n_ov[3] - s_ov, 1);
        for (int i = 1; i <= 4; i++) begin
            pop_d(got);
            check_eq($sformatf("d_pop_%0d", i), got, 8'(8'h11 * i));
        end
        check_eq("d_drained", {rx_valid_d, cnt_d}, 4'h0);

        // quarter-bit glitch is a false start
        snap(3);
        rxd[3] = 1'b0;
        repeat (FB / 4) @(negedge clk);
        rxd[3] = 1'b1;
        repeat (3 * FB) @(negedge clk);
        check_eq("d_glitch_count", cnt_d, 3'd0);
        check_eq("d_glitch_errors", (n_pe[3] - s_pe) + (n_fe[3] - s_fe) + (n_bd[3] - s_bd), 0);

        // reset mid-DATA with a word already queued
        send_frame(3, {1'b1, 8'h5A, 1'b0}, 10, FB);
        check_eq("d_pre_reset_count", cnt_d, 3'd1);
        rxd[3] = 1'b0;
        repeat (FB) @(negedge clk);
        rxd[3] = 1'b1;
        repeat (FB) @(negedge clk);
        rxd[3] = 1'b0;
        repeat (FB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("d_rst_outputs", {rx_valid_d, cnt_d, pe[3], fe[3], bd[3], ov[3]}, 8'h0);
        rxd[3] = 1'b1;
        rst_n = 1'b1;
        repeat (3 * FB) @(negedge clk);
        check_eq("d_post_reset_idle", cnt_d, 3'd0);
        send_frame(3, {1'b1, 8'hF0, 1'b0}, 10, FB);
        check_eq("d_post_reset_count", cnt_d, 3'd1);
        check_eq("d_post_reset_data", rx_data_d, 8'hF0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
